fetch_pc_ctrl: RTL and testbench

Registered program-counter controller for the pipelined Y86-64 fetch stage. Holds the fetch PC, predicts the next PC from the instruction being fetched, and redirects on late-resolved control flow: jXX mispredicts from memory and ret targets from write-back. Width and reset vector are parametrised. An optional return-address stack predicts ret targets instead of stalling fetch.

---
 rtl/y86_pkg.sv | 29 ++
 rtl/fetch_pc_ctrl_if.sv | 33 +++
 rtl/ret_addr_stack.sv | 60 ++++++
 rtl/fetch_pc_ctrl.sv | 170 +++++++++++++++++
 tb/tb_fetch_pc_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the fetch stage: instruction codes, the
// fetch-state encoding and a small icode classification helper.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_RET_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } fetch_state_e;

  // Codes above IPOPQ do not exist; fetch stops on them exactly as on halt.
  function automatic logic is_halt_like(input logic [3:0] icode);
    return (icode == IHALT) || (icode > IPOPQ);
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-PC control bundle: the fetched instruction, late redirects from the
// memory and write-back stages, and the PC/status returned to the pipeline.
interface fetch_pc_ctrl_if #(
  parameter int ADDR_W = 64
);
  logic              f_valid;
  logic              f_stall;
  logic [3:0]        f_icode;
  logic [ADDR_W-1:0] f_valC;
  logic [ADDR_W-1:0] f_valP;
  logic              m_mispredict;
  logic [ADDR_W-1:0] m_valA;
  logic              w_ret;
  logic [ADDR_W-1:0] w_valM;
  logic [ADDR_W-1:0] pc;
  logic              ret_wait;
  logic              halted;
  logic              ret_flush;

  // Pipeline side: supplies the instruction and redirects, consumes the PC.
  modport master (
    output f_valid, f_stall, f_icode, f_valC, f_valP,
    output m_mispredict, m_valA, w_ret, w_valM,
    input  pc, ret_wait, halted, ret_flush
  );

  // PC controller side.
  modport slave (
    input  f_valid, f_stall, f_icode, f_valC, f_valP,
    input  m_mispredict, m_valA, w_ret, w_valM,
    output pc, ret_wait, halted, ret_flush
  );
endinterface

// File: rtl/ret_addr_stack.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; a pop when empty is ignored. top is valid only while !empty.
module ret_addr_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0] top_idx;

  // Pointer/occupancy update; ptr_q is the next free slot, wrapping at DEPTH.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (cnt_q != FULL_CNT) cnt_d = cnt_q + (PTR_W + 1)'(1);
    end else if (pop && (cnt_q != '0)) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - (PTR_W + 1)'(1);
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; cnt_q marks which entries are meaningful.
    if (push) mem_q[ptr_q] <= push_data;
  end

  assign top_idx = ptr_q - PTR_W'(1);
  assign top     = mem_q[top_idx];
  assign empty   = (cnt_q == '0);

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch program-counter controller for the pipelined Y86-64.
// Predicts the next PC from the fetched instruction (jXX always taken, call
// to its target) and redirects on jXX mispredicts and resolved ret targets.
// Build option FETCH_PC_RAS_EN: a return-address stack predicts ret targets;
// a wrong prediction is repaired at write-back with a ret_flush pulse.
// Without it every ret holds fetch until its target arrives from write-back.
module fetch_pc_ctrl
  import y86_pkg::*;
#(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                RAS_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  fetch_pc_ctrl_if.slave  bus
);

  if ((RAS_DEPTH < 2) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("RAS_DEPTH must be a power of two >= 2");
  end

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              ret_wait_q, ret_wait_d;
  logic              halted_q, halted_d;
  logic              redirect;
  logic              w_ret_free;

`ifdef FETCH_PC_RAS_EN
  logic              ret_flush_q, ret_flush_d;
  logic              spec_q, spec_d;
  logic [ADDR_W-1:0] spec_pc_q, spec_pc_d;
  logic              ras_push, ras_pop, ras_empty;
  logic [ADDR_W-1:0] ras_top;

  ret_addr_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (bus.f_valP),
    .top       (ras_top),
    .empty     (ras_empty)
  );
`endif

  // Next PC and state: mispredict, then ret resolution, then stall, then prediction.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    redirect   = 1'b0;
    w_ret_free = bus.w_ret;
`ifdef FETCH_PC_RAS_EN
    spec_d      = spec_q;
    spec_pc_d   = spec_pc_q;
    ret_flush_d = 1'b0;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
`endif

    if (bus.m_mispredict) begin
      // Everything younger than the jXX is squashed, including a halt or a
      // speculated ret, so the outstanding-ret flag goes with it.
      pc_d     = bus.m_valA;
      state_d  = ST_RUN;
      redirect = 1'b1;
`ifdef FETCH_PC_RAS_EN
      spec_d   = 1'b0;
`endif
    end
`ifdef FETCH_PC_RAS_EN
    else if (bus.w_ret && spec_q) begin
      // This w_ret resolves the speculated ret; it never releases RET_WAIT.
      w_ret_free = 1'b0;
      spec_d     = 1'b0;
      if ((bus.w_valM != spec_pc_q) && (state_q != ST_HALT)) begin
        pc_d        = bus.w_valM;
        state_d     = ST_RUN;
        ret_flush_d = 1'b1;
        redirect    = 1'b1;
      end
    end
`endif

    if (!redirect) begin
      case (state_q)
        ST_RUN: begin
          if (bus.f_valid && !bus.f_stall) begin
            if (is_halt_like(bus.f_icode)) begin
              state_d = ST_HALT;
            end else if ((bus.f_icode == IJXX) || (bus.f_icode == ICALL)) begin
              pc_d = bus.f_valC;
`ifdef FETCH_PC_RAS_EN
              ras_push = (bus.f_icode == ICALL);
`endif
            end else if (bus.f_icode == IRET) begin
`ifdef FETCH_PC_RAS_EN
              if (!ras_empty && !spec_d) begin
                pc_d      = ras_top;
                ras_pop   = 1'b1;
                spec_d    = 1'b1;
                spec_pc_d = ras_top;
              end else begin
                state_d = ST_RET_WAIT;
              end
`else
              state_d = ST_RET_WAIT;
`endif
            end else begin
              pc_d = bus.f_valP;
            end
          end
        end
        ST_RET_WAIT: begin
          if (w_ret_free) begin
            pc_d    = bus.w_valM;
            state_d = ST_RUN;
          end
        end
        default: ;
      endcase
    end

    ret_wait_d = (state_d == ST_RET_WAIT);
    halted_d   = (state_d == ST_HALT);
  end

  // PC, state and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      ret_wait_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ret_wait_q <= ret_wait_d;
      halted_q   <= halted_d;
    end
  end

`ifdef FETCH_PC_RAS_EN
  // Outstanding speculated ret and the flush pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      spec_q      <= 1'b0;
      spec_pc_q   <= '0;
      ret_flush_q <= 1'b0;
    end else begin
      spec_q      <= spec_d;
      spec_pc_q   <= spec_pc_d;
      ret_flush_q <= ret_flush_d;
    end
  end

  assign bus.ret_flush = ret_flush_q;
`else
  assign bus.ret_flush = 1'b0;
`endif

  assign bus.pc       = pc_q;
  assign bus.ret_wait = ret_wait_q;
  assign bus.halted   = halted_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
// Builds with or without FETCH_PC_RAS_EN.
module tb_fetch_pc_ctrl;

  localparam int          ADDR_W    = 64;
  localparam logic [63:0] RESET_PC  = 64'h100;
  localparam int          RAS_DEPTH = 8;
`ifdef FETCH_PC_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_pc_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  fetch_pc_ctrl #(
    .ADDR_W    (ADDR_W),
    .RESET_PC  (RESET_PC),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: architectural view of the fetch PC.
  logic [63:0] m_pc;
  bit          m_wait, m_halt, m_flush, m_spec;
  logic [63:0] m_spec_pc;
  logic [63:0] m_ras[$];

  function automatic void model_reset();
    m_pc = RESET_PC; m_wait = 0; m_halt = 0; m_flush = 0; m_spec = 0; m_spec_pc = '0;
    m_ras.delete();
  endfunction

  function automatic void model_step(input bit v, s, input logic [3:0] ic,
                                     input logic [63:0] c, p, input bit mm,
                                     input logic [63:0] ma, input bit wr,
                                     input logic [63:0] wm);
    bit own  = 0;   // this w_ret belongs to the speculated ret
    bit done = 0;
    m_flush = 0;
    if (mm) begin
      m_pc = ma; m_wait = 0; m_halt = 0; m_spec = 0;
      return;
    end
    if (wr && m_spec) begin
      m_spec = 0; own = 1;
      if (wm != m_spec_pc && !m_halt) begin
        m_pc = wm; m_wait = 0; m_flush = 1; done = 1;
      end
    end
    if (done || m_halt) return;
    if (m_wait) begin
      if (wr && !own) begin m_pc = wm; m_wait = 0; end
      return;
    end
    if (!v || s) return;
    if (ic == 4'h0 || ic > 4'hB) m_halt = 1;
    else if (ic == 4'h7) m_pc = c;
    else if (ic == 4'h8) begin
      m_pc = c;
      if (RAS_EN) begin
        m_ras.push_back(p);
        if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
      end
    end else if (ic == 4'h9) begin
      if (RAS_EN && m_ras.size() > 0 && !m_spec) begin
        m_pc = m_ras.pop_back(); m_spec = 1; m_spec_pc = m_pc;
      end else m_wait = 1;
    end else m_pc = p;
  endfunction

  task automatic compare_all();
    check("pc", bus.pc, m_pc);
    check("ret_wait", 64'(bus.ret_wait), 64'(m_wait));
    check("halted", 64'(bus.halted), 64'(m_halt));
    check("ret_flush", 64'(bus.ret_flush), 64'(m_flush));
  endtask

  task automatic step(input bit v, s, input logic [3:0] ic, input logic [63:0] c, p,
                      input bit mm, input logic [63:0] ma, input bit wr, input logic [63:0] wm);
    bus.f_valid = v; bus.f_stall = s; bus.f_icode = ic; bus.f_valC = c; bus.f_valP = p;
    bus.m_mispredict = mm; bus.m_valA = ma; bus.w_ret = wr; bus.w_valM = wm;
    model_step(v, s, ic, c, p, mm, ma, wr, wm);
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.f_valid = 0; bus.f_stall = 0; bus.f_icode = '0; bus.f_valC = '0; bus.f_valP = '0;
    bus.m_mispredict = 0; bus.m_valA = '0; bus.w_ret = 0; bus.w_valM = '0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    compare_all();
  endtask

  // Shorthands for common cycles.
  task automatic fetch(input logic [3:0] ic, input logic [63:0] c, p);
    step(1, 0, ic, c, p, 0, '0, 0, '0);
  endtask
  task automatic idle();
    step(0, 0, 4'h1, '0, '0, 0, '0, 0, '0);
  endtask
  task automatic wret(input logic [63:0] wm);
    step(0, 0, 4'h1, '0, '0, 0, '0, 1, wm);
  endtask

  task automatic rand_cycle();
    bit v, s, mm, wr;
    logic [3:0] ic;
    logic [63:0] c, p, ma, wm;
    int r;
    if ($urandom_range(0, 299) == 0) begin do_reset(); return; end
    v  = ($urandom_range(0, 9) < 8);
    s  = ($urandom_range(0, 9) == 0);
    r  = $urandom_range(0, 99);
    if (r < 2)       ic = 4'h0;
    else if (r < 4)  ic = 4'($urandom_range(12, 15));
    else if (r < 20) ic = 4'h7;
    else if (r < 38) ic = 4'h8;
    else if (r < 56) ic = 4'h9;
    else if (r < 80) ic = 4'($urandom_range(1, 6));
    else             ic = 4'($urandom_range(10, 11));
    c  = {32'h0, $urandom};
    p  = {32'h0, $urandom};
    mm = ($urandom_range(0, 24) == 0);
    ma = {$urandom, $urandom};
    wr = ($urandom_range(0, 4) == 0);
    wm = (m_spec && $urandom_range(0, 1) == 1) ? m_spec_pc : {32'h0, $urandom};
    step(v, s, ic, c, p, mm, ma, wr, wm);
  endtask

  initial begin
    // Reset vector and fall-through prediction.
    do_reset();
    check("tp_reset_pc", bus.pc, 64'h100);
    fetch(4'h3, 64'h0, 64'h10A);
    check("tp_irmovq", bus.pc, 64'h10A);

    // jXX taken prediction, then mispredict repair.
    fetch(4'h7, 64'h200, 64'h113);
    check("tp_jxx", bus.pc, 64'h200);
    idle();
    step(0, 0, 4'h1, '0, '0, 1, 64'h113, 0, '0);
    check("tp_mispredict", bus.pc, 64'h113);

    // Stall holds PC.
    step(1, 1, 4'h7, 64'h999, 64'h115, 0, '0, 0, '0);
    check("tp_stall", bus.pc, 64'h113);

    // ret with nothing predicted: wait for write-back, f_valid ignored.
    fetch(4'h9, '0, 64'h114);
    check("tp_ret_wait", 64'(bus.ret_wait), 64'h1);
    for (int i = 0; i < 3; i++) fetch(4'h7, 64'h777, 64'h888);
    check("tp_ret_hold", bus.pc, 64'h113);
    wret(64'h140);
    check("tp_ret_release", bus.pc, 64'h140);
    check("tp_ret_wait_clr", 64'(bus.ret_wait), 64'h0);

    // Simultaneous mispredict and w_ret: mispredict wins.
    fetch(4'h9, '0, 64'h141);
    step(0, 0, 4'h1, '0, '0, 1, 64'h50, 1, 64'h90);
    check("tp_mm_beats_wret", bus.pc, 64'h50);

    // call/ret pair, correct then wrong ret target.
    do_reset();
    fetch(4'h8, 64'h1000, 64'h30);
    fetch(4'h9, '0, 64'h1001);
`ifdef FETCH_PC_RAS_EN
    check("tp_ras_predict", bus.pc, 64'h30);
`endif
    wret(64'h30);
    check("tp_ret_ok_pc", bus.pc, 64'h30);
    fetch(4'h8, 64'h1000, 64'h30);
    fetch(4'h9, '0, 64'h1001);
    wret(64'h44);
    check("tp_ret_wrong_pc", bus.pc, 64'h44);
`ifdef FETCH_PC_RAS_EN
    check("tp_ret_flush", 64'(bus.ret_flush), 64'h1);
`endif
    idle();
    check("tp_flush_pulse_end", 64'(bus.ret_flush), 64'h0);

    // Overflow: RAS_DEPTH+1 nested calls, then the matching rets.
    do_reset();
    for (int i = 0; i <= RAS_DEPTH; i++) fetch(4'h8, 64'h2000, 64'h1000 + 64'(16 * i));
    for (int k = 0; k <= RAS_DEPTH; k++) begin
      fetch(4'h9, '0, 64'h3000);
`ifdef FETCH_PC_RAS_EN
      if (k < RAS_DEPTH) check("tp_ovf_predict", bus.pc, 64'h1000 + 64'(16 * (RAS_DEPTH - k)));
      else               check("tp_ovf_wait", 64'(bus.ret_wait), 64'h1);
`endif
      wret(64'h1000 + 64'(16 * (RAS_DEPTH - k)));
    end
    check("tp_ovf_last", bus.pc, 64'h1000);

    // Halt freezes fetch until reset; illegal icode halts; mispredict revives.
    fetch(4'h0, 64'h5, 64'h6);
    check("tp_halted", 64'(bus.halted), 64'h1);
    for (int i = 0; i < 4; i++) step(1, 0, 4'h7, 64'h4444, 64'h5555, 0, '0, 1, 64'h6666);
    check("tp_halt_frozen", bus.pc, 64'h1000);
    do_reset();
    check("tp_halt_reset", 64'(bus.halted), 64'h0);
    fetch(4'hD, 64'h5, 64'h6);
    check("tp_illegal_halt", 64'(bus.halted), 64'h1);
    step(0, 0, 4'h1, '0, '0, 1, 64'h77, 0, '0);
    check("tp_halt_mispredict", bus.pc, 64'h77);

    // Random traffic.
    for (int n = 0; n < 4000; n++) rand_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
